// File: rtl/board_link_uart.sv
// board_link_uart: inter-board 8N1 serial link for two-player mode.
//  TX: level-request byte stream -> push filter -> small FIFO -> UART frame serialiser.
//  RX: 2-FF synchronised line -> 16x oversampled deserialiser -> last good byte held.
// Ports:
//  clk65MHz, rst (synchronous, active-high)
//  tx_byte[7:0], tx_valid      byte command stream from the game
//  tx_full, tx_overflow        FIFO full / sticky dropped-push flag
//  uart_tx, uart_rx            board pins (idle high)
//  rx_byte[7:0], rx_strobe     last correctly framed byte and its update pulse
//  rx_frame_err                pulse on a bad stop bit (or bad parity)
// Optional build macro: LINK_PARITY_EN adds an even-parity bit after D7 (11-bit frame).
module board_link_uart #(
   parameter int unsigned CLK_HZ     = 65_000_000,
   parameter int unsigned BAUD       = 115_200,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       clk65MHz,
   input  logic       rst,
   input  logic [7:0] tx_byte,
   input  logic       tx_valid,
   output logic       tx_full,
   output logic       tx_overflow,
   output logic       uart_tx,
   input  logic       uart_rx,
   output logic [7:0] rx_byte,
   output logic       rx_strobe,
   output logic       rx_frame_err
);
   localparam int unsigned TICK_DIV = CLK_HZ / (BAUD * 16);
   localparam int unsigned BIT_CLKS = TICK_DIV * 16;
   localparam int unsigned DIV_W    = $clog2(TICK_DIV + 1);
   localparam int unsigned BIT_W    = $clog2(BIT_CLKS);
   localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W    = PTR_W + 1;

   // ---------------- TX push filter and FIFO ----------------
   logic             tx_valid_q;
   logic [7:0]       last_push;
   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] fifo_cnt, fifo_cnt_next;
   logic             fifo_empty, fifo_is_full;
   logic             push_req, push_ok, pop;
   logic [7:0]       tx_head;

   // A held request only pushes again if the byte changes.
   assign push_req     = tx_valid && (!tx_valid_q || (tx_byte != last_push));
   assign fifo_empty   = (fifo_cnt == '0);
   assign fifo_is_full = (fifo_cnt == CNT_W'(FIFO_DEPTH));
   // A simultaneous pop frees the slot, so a push while full is still accepted.
   assign push_ok      = push_req && (!fifo_is_full || pop);
   assign tx_head      = fifo_mem[rd_ptr];

   always_comb begin
      fifo_cnt_next = fifo_cnt;
      case ({push_ok, pop})
         2'b10:   fifo_cnt_next = fifo_cnt + CNT_W'(1);
         2'b01:   fifo_cnt_next = fifo_cnt - CNT_W'(1);
         default: fifo_cnt_next = fifo_cnt;
      endcase
   end

   // FIFO storage (no reset needed: validity tracked by fifo_cnt).
   always_ff @(posedge clk65MHz) begin
      if (push_ok) fifo_mem[wr_ptr] <= tx_byte;
   end

   // FIFO pointers, status flags and push history.
   always_ff @(posedge clk65MHz) begin
      if (rst) begin
         tx_valid_q  <= 1'b0;
         last_push   <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_cnt    <= '0;
         tx_full     <= 1'b0;
         tx_overflow <= 1'b0;
      end else begin
         tx_valid_q <= tx_valid;
         if (push_req) last_push <= tx_byte;
         if (push_ok)  wr_ptr    <= wr_ptr + PTR_W'(1);
         if (pop)      rd_ptr    <= rd_ptr + PTR_W'(1);
         fifo_cnt <= fifo_cnt_next;
         tx_full  <= (fifo_cnt_next == CNT_W'(FIFO_DEPTH));
         if (push_req && !push_ok) tx_overflow <= 1'b1;
      end
   end

   // ---------------- Free-running 16x baud tick ----------------
   logic [DIV_W-1:0] div_cnt;
   logic             baud_tick;

   always_ff @(posedge clk65MHz) begin
      if (rst) begin
         div_cnt   <= '0;
         baud_tick <= 1'b0;
      end else if (div_cnt == DIV_W'(TICK_DIV - 1)) begin
         div_cnt   <= '0;
         baud_tick <= 1'b1;
      end else begin
         div_cnt   <= div_cnt + DIV_W'(1);
         baud_tick <= 1'b0;
      end
   end

   // ---------------- TX serialiser ----------------
   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
`ifdef LINK_PARITY_EN
      TX_PARITY,
`endif
      TX_STOP
   } tx_state_t;

   tx_state_t        tx_state, tx_state_n;
   logic [BIT_W-1:0] tx_timer, tx_timer_n;
   logic [2:0]       tx_bit, tx_bit_n;
   logic [7:0]       tx_shift, tx_shift_n;
   logic             uart_tx_n;
   logic             tx_bit_end;
`ifdef LINK_PARITY_EN
   logic             tx_par, tx_par_n;
`endif

   assign tx_bit_end = (tx_timer == BIT_W'(BIT_CLKS - 1));

   always_ff @(posedge clk65MHz) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         tx_timer <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         uart_tx  <= 1'b1;
`ifdef LINK_PARITY_EN
         tx_par   <= 1'b0;
`endif
      end else begin
         tx_state <= tx_state_n;
         tx_timer <= tx_timer_n;
         tx_bit   <= tx_bit_n;
         tx_shift <= tx_shift_n;
         uart_tx  <= uart_tx_n;
`ifdef LINK_PARITY_EN
         tx_par   <= tx_par_n;
`endif
      end
   end

   // Next-state: uart_tx is registered and changes on the edge that enters each bit.
   always_comb begin
      tx_state_n = tx_state;
      tx_timer_n = tx_bit_end ? '0 : tx_timer + BIT_W'(1);
      tx_bit_n   = tx_bit;
      tx_shift_n = tx_shift;
      uart_tx_n  = uart_tx;
      pop        = 1'b0;
`ifdef LINK_PARITY_EN
      tx_par_n   = tx_par;
`endif
      case (tx_state)
         TX_IDLE: begin
            tx_timer_n = '0;
            uart_tx_n  = 1'b1;
            if (!fifo_empty) begin
               pop        = 1'b1;
               tx_shift_n = tx_head;
               uart_tx_n  = 1'b0;
               tx_state_n = TX_START;
`ifdef LINK_PARITY_EN
               tx_par_n   = ^tx_head;
`endif
            end
         end
         TX_START: begin
            if (tx_bit_end) begin
               tx_bit_n   = '0;
               uart_tx_n  = tx_shift[0];
               tx_state_n = TX_DATA;
            end
         end
         TX_DATA: begin
            if (tx_bit_end) begin
               tx_shift_n = {1'b0, tx_shift[7:1]};
               tx_bit_n   = tx_bit + 3'd1;
               if (tx_bit == 3'd7) begin
`ifdef LINK_PARITY_EN
                  uart_tx_n  = tx_par;
                  tx_state_n = TX_PARITY;
`else
                  uart_tx_n  = 1'b1;
                  tx_state_n = TX_STOP;
`endif
               end else begin
                  uart_tx_n = tx_shift[1];
               end
            end
         end
`ifdef LINK_PARITY_EN
         TX_PARITY: begin
            if (tx_bit_end) begin
               uart_tx_n  = 1'b1;
               tx_state_n = TX_STOP;
            end
         end
`endif
         TX_STOP: begin
            if (tx_bit_end) begin
               if (!fifo_empty) begin
                  // Chain straight into the next start bit: no idle gap.
                  pop        = 1'b1;
                  tx_shift_n = tx_head;
                  uart_tx_n  = 1'b0;
                  tx_state_n = TX_START;
`ifdef LINK_PARITY_EN
                  tx_par_n   = ^tx_head;
`endif
               end else begin
                  tx_state_n = TX_IDLE;
               end
            end
         end
         default: begin
            uart_tx_n  = 1'b1;
            tx_state_n = TX_IDLE;
         end
      endcase
   end

   // ---------------- RX deserialiser ----------------
   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
`ifdef LINK_PARITY_EN
      RX_PARITY,
`endif
      RX_STOP,
      RX_BREAK
   } rx_state_t;

   rx_state_t  rx_state, rx_state_n;
   logic [1:0] rx_sync;
   logic       rx_s;
   logic [3:0] rx_ticks, rx_ticks_n;
   logic [2:0] rx_bit, rx_bit_n;
   logic [7:0] rx_shift, rx_shift_n;
   logic [7:0] rx_byte_n;
   logic       rx_strobe_n, rx_frame_err_n;
   logic       rx_frame_ok;
`ifdef LINK_PARITY_EN
   logic       rx_par_err, rx_par_err_n;
   assign rx_frame_ok = rx_s && !rx_par_err;
`else
   assign rx_frame_ok = rx_s;
`endif

   assign rx_s = rx_sync[1];

   always_ff @(posedge clk65MHz) begin
      if (rst) begin
         rx_sync      <= 2'b11;
         rx_state     <= RX_IDLE;
         rx_ticks     <= '0;
         rx_bit       <= '0;
         rx_shift     <= '0;
         rx_byte      <= '0;
         rx_strobe    <= 1'b0;
         rx_frame_err <= 1'b0;
`ifdef LINK_PARITY_EN
         rx_par_err   <= 1'b0;
`endif
      end else begin
         rx_sync      <= {rx_sync[0], uart_rx};
         rx_state     <= rx_state_n;
         rx_ticks     <= rx_ticks_n;
         rx_bit       <= rx_bit_n;
         rx_shift     <= rx_shift_n;
         rx_byte      <= rx_byte_n;
         rx_strobe    <= rx_strobe_n;
         rx_frame_err <= rx_frame_err_n;
`ifdef LINK_PARITY_EN
         rx_par_err   <= rx_par_err_n;
`endif
      end
   end

   // 4-bit tick counter wraps 15 -> 0, so each full-bit wait restarts by itself.
   always_comb begin
      rx_state_n     = rx_state;
      rx_ticks_n     = rx_ticks;
      rx_bit_n       = rx_bit;
      rx_shift_n     = rx_shift;
      rx_byte_n      = rx_byte;
      rx_strobe_n    = 1'b0;
      rx_frame_err_n = 1'b0;
`ifdef LINK_PARITY_EN
      rx_par_err_n   = rx_par_err;
`endif
      case (rx_state)
         RX_IDLE: begin
            rx_ticks_n = '0;
            if (!rx_s) rx_state_n = RX_START;
         end
         RX_START: begin
            if (baud_tick) begin
               if (rx_ticks == 4'd7) begin
                  rx_ticks_n = '0;
                  rx_bit_n   = '0;
                  rx_state_n = rx_s ? RX_IDLE : RX_DATA;
`ifdef LINK_PARITY_EN
                  rx_par_err_n = 1'b0;
`endif
               end else begin
                  rx_ticks_n = rx_ticks + 4'd1;
               end
            end
         end
         RX_DATA: begin
            if (baud_tick) begin
               rx_ticks_n = rx_ticks + 4'd1;
               if (rx_ticks == 4'd15) begin
                  rx_shift_n = {rx_s, rx_shift[7:1]};
                  rx_bit_n   = rx_bit + 3'd1;
`ifdef LINK_PARITY_EN
                  if (rx_bit == 3'd7) rx_state_n = RX_PARITY;
`else
                  if (rx_bit == 3'd7) rx_state_n = RX_STOP;
`endif
               end
            end
         end
`ifdef LINK_PARITY_EN
         RX_PARITY: begin
            if (baud_tick) begin
               rx_ticks_n = rx_ticks + 4'd1;
               if (rx_ticks == 4'd15) begin
                  rx_par_err_n = rx_s ^ (^rx_shift);
                  rx_state_n   = RX_STOP;
               end
            end
         end
`endif
         RX_STOP: begin
            if (baud_tick) begin
               rx_ticks_n = rx_ticks + 4'd1;
               if (rx_ticks == 4'd15) begin
                  if (rx_frame_ok) begin
                     rx_byte_n   = rx_shift;
                     rx_strobe_n = 1'b1;
                  end else begin
                     rx_frame_err_n = 1'b1;
                  end
                  // A low stop bit means a break: wait for the line to recover.
                  rx_state_n = rx_s ? RX_IDLE : RX_BREAK;
               end
            end
         end
         RX_BREAK: begin
            if (rx_s) rx_state_n = RX_IDLE;
         end
         default: rx_state_n = RX_IDLE;
      endcase
   end

endmodule
